// File: rtl/multi_cycle_cpu.sv
// -----------------------------------------------------------------------------
// multi_cycle_cpu
//
// Multi-cycle RV32I subset core. Every instruction walks through a
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK state machine that shares a
// single ALU. Instruction memory, data memory and the register file are held
// in flops so that they can be preloaded on reset and observed directly.
//
// Supported: R/I ALU ops, LW, SW, BEQ, BNE, JAL. Anything else halts.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-high; loads preload arrays
//   initial_instructions     imem image, copied in while reset is high
//   initial_register_values  register image, copied in while reset is high
//                            (entry 0 ignored, x0 is always zero)
//   pc_out_check             current program counter
//   instruction_check        instruction register
//   state_check              FSM state (FETCH=0 .. HALT=5)
//   halted                   high while in HALT
//   retired_count            number of completed instructions (wraps)
//   register_check           register file contents
//   dmem_check               data memory contents
// -----------------------------------------------------------------------------
module multi_cycle_cpu #(
   parameter int          IMEM_DEPTH = 32,
   parameter int          DMEM_DEPTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] initial_instructions    [IMEM_DEPTH],
   input  logic [31:0] initial_register_values [32],
   output logic [31:0] pc_out_check,
   output logic [31:0] instruction_check,
   output logic [2:0]  state_check,
   output logic        halted,
   output logic [31:0] retired_count,
   output logic [31:0] register_check [32],
   output logic [31:0] dmem_check     [DMEM_DEPTH]
);

   localparam int          IW         = $clog2(IMEM_DEPTH);
   localparam int          DW         = $clog2(DMEM_DEPTH);
   localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
   } alu_op_t;

   // ---------------------------------------------------------------------------
   // Architectural and micro-architectural state
   // ---------------------------------------------------------------------------
   state_t          state;
   logic [31:0]     pc;
   logic [31:0]     ir;
   logic [31:0]     a;          // rs1 data latched in DECODE
   logic [31:0]     b;          // rs2 data latched in DECODE
   logic [31:0]     imm;        // immediate latched in DECODE
   logic [31:0]     result;     // ALU result, link address or load data
   logic [31:0]     target;     // JAL target, applied on the final edge
   logic [DW-1:0]   dmem_idx;   // wrapped data word index
   logic [31:0]     retired;
   logic [31:0]     regs [32];
   logic [31:0]     imem [IMEM_DEPTH];
   logic [31:0]     dmem [DMEM_DEPTH];

   // ---------------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd, rs1, rs2;
   logic       bit30;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign bit30  = ir[30];

   // Immediate selected by format; I-format covers OP_I and LW.
   logic [31:0] imm_dec;
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      imm_dec = {{20{ir[31]}}, ir[31:20]};
      case (opcode)
         OP_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:   ;
      endcase
   end

   // Opcode / funct3 legality, evaluated in DECODE.
   logic legal;
   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_JAL: legal = 1'b1;
         OP_LOAD, OP_STORE:  legal = (funct3 == 3'b010);
         OP_BRANCH:          legal = (funct3 == 3'b000) || (funct3 == 3'b001);
         default:            legal = 1'b0;
      endcase
   end

   // ALU operation. SUB exists only in R-type; bit 30 picks SRA for both.
   alu_op_t alu_op;
   always_comb begin
      alu_op = ALU_ADD;
      if (opcode == OP_R || opcode == OP_I) begin
         case (funct3)
            3'b000:  alu_op = (opcode == OP_R && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Shared ALU: branch/JAL targets use pc as the first operand, everything
   // else uses rs1. Only R-type takes rs2 as the second operand.
   // ---------------------------------------------------------------------------
   logic [31:0] alu_a, alu_b, alu_y;
   assign alu_a = (opcode == OP_BRANCH || opcode == OP_JAL) ? pc : a;
   assign alu_b = (opcode == OP_R) ? b : imm;

   always_comb begin
      alu_y = 32'h0;
      case (alu_op)
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLL:  alu_y = alu_a << alu_b[4:0];
         ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
         ALU_XOR:  alu_y = alu_a ^ alu_b;
         ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_AND:  alu_y = alu_a & alu_b;
         default:  alu_y = 32'h0;
      endcase
   end

   logic [31:0] pc_plus4;
   logic        branch_taken;
   logic        fetch_bad;

   assign pc_plus4     = pc + 32'd4;
   assign branch_taken = (a == b) ^ funct3[0];   // funct3[0]=1 is BNE
   assign fetch_bad    = (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);

   // ---------------------------------------------------------------------------
   // FSM and datapath. All architectural updates (regs, dmem, pc, retired)
   // happen on the last edge of an instruction, so a reset in the middle of
   // one leaves nothing half-written.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         ir       <= 32'h0;
         a        <= 32'h0;
         b        <= 32'h0;
         imm      <= 32'h0;
         result   <= 32'h0;
         target   <= 32'h0;
         dmem_idx <= '0;
         retired  <= 32'h0;
         // NOTE: these memories are flop arrays with a defined power-on image,
         // so resetting them is intentional; a RAM macro could not do this.
         regs[0]  <= 32'h0;
         for (int i = 1; i < 32; i++) regs[i] <= initial_register_values[i];
         for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= initial_instructions[i];
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               ir    <= imem[pc[IW+1:2]];
               state <= fetch_bad ? HALT : DECODE;
            end

            DECODE: begin
               a     <= regs[rs1];
               b     <= regs[rs2];
               imm   <= imm_dec;
               state <= legal ? EXECUTE : HALT;
            end

            EXECUTE: begin
               case (opcode)
                  OP_R, OP_I: begin
                     result <= alu_y;
                     state  <= WRITEBACK;
                  end
                  OP_LOAD, OP_STORE: begin
                     dmem_idx <= alu_y[DW+1:2];   // upper address bits wrap
                     state    <= MEMORY;
                  end
                  OP_BRANCH: begin
                     pc      <= branch_taken ? alu_y : pc_plus4;
                     retired <= retired + 32'd1;
                     state   <= FETCH;
                  end
                  OP_JAL: begin
                     result <= pc_plus4;
                     target <= alu_y;
                     state  <= WRITEBACK;
                  end
                  default: state <= HALT;
               endcase
            end

            MEMORY: begin
               if (opcode == OP_LOAD) begin
                  result <= dmem[dmem_idx];
                  state  <= WRITEBACK;
               end else begin
                  dmem[dmem_idx] <= b;
                  pc             <= pc_plus4;
                  retired        <= retired + 32'd1;
                  state          <= FETCH;
               end
            end

            WRITEBACK: begin
               if (rd != 5'd0) regs[rd] <= result;
               pc      <= (opcode == OP_JAL) ? target : pc_plus4;
               retired <= retired + 32'd1;
               state   <= FETCH;
            end

            HALT:    state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Observation ports
   // ---------------------------------------------------------------------------
   assign pc_out_check      = pc;
   assign instruction_check = ir;
   assign state_check       = state;
   assign halted            = (state == HALT);
   assign retired_count     = retired;
   assign register_check    = regs;
   assign dmem_check        = dmem;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_cpu
//
// Self-checking bench for multi_cycle_cpu: a table of single-instruction ALU
// vectors routed through a scoreboard queue, followed by hand-written programs
// for loads/stores, address wrap, branches, JAL, halting and mid-op reset.
// -----------------------------------------------------------------------------
module tb_multi_cycle_cpu;

   localparam int          IMEM_DEPTH = 32;
   localparam int          DMEM_DEPTH = 32;
   localparam logic [31:0] ECALL      = 32'h0000_0073;
   localparam logic [6:0]  OP_I       = 7'b0010011;
   localparam logic [6:0]  OP_LOAD    = 7'b0000011;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] init_imem [IMEM_DEPTH];
   logic [31:0] init_regs [32];
   logic [31:0] pc_chk, ir_chk, retired_chk;
   logic [2:0]  state_chk;
   logic        halted;
   logic [31:0] reg_chk  [32];
   logic [31:0] dmem_chk [DMEM_DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multi_cycle_cpu #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .DMEM_DEPTH (DMEM_DEPTH),
      .RESET_PC   (32'h0)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .initial_instructions    (init_imem),
      .initial_register_values (init_regs),
      .pc_out_check            (pc_chk),
      .instruction_check       (ir_chk),
      .state_check             (state_chk),
      .halted                  (halted),
      .retired_count           (retired_chk),
      .register_check          (reg_chk),
      .dmem_check              (dmem_chk)
   );

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         $display("FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
         n_fail++;
      end
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   // ---------------- helpers ----------------
   task automatic clear_program();
      for (int i = 0; i < IMEM_DEPTH; i++) init_imem[i] = ECALL;
      for (int i = 0; i < 32; i++) init_regs[i] = 32'h0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- vector table and scoreboard ----------------
   typedef struct {
      string       name;
      bit          is_imm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expv;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   vec_t vecs [$];
   exp_t sb   [$];

   initial begin
      exp_t e;
      int   cyc;
      int   mism;

      vecs.push_back('{"add",   1'b0, 7'h00, 3'd0, 12'h000, 32'd5,         32'hFFFF_FFFD, 32'd2});
      vecs.push_back('{"sub",   1'b0, 7'h20, 3'd0, 12'h000, 32'd5,         32'hFFFF_FFFD, 32'd8});
      vecs.push_back('{"sltu",  1'b0, 7'h00, 3'd3, 12'h000, 32'd5,         32'hFFFF_FFFD, 32'd1});
      vecs.push_back('{"slt+",  1'b0, 7'h00, 3'd2, 12'h000, 32'd5,         32'hFFFF_FFFD, 32'd0});
      vecs.push_back('{"slt-",  1'b0, 7'h00, 3'd2, 12'h000, 32'hFFFF_FFFD, 32'd5,         32'd1});
      vecs.push_back('{"sll",   1'b0, 7'h00, 3'd1, 12'h000, 32'd1,         32'd33,        32'd2});
      vecs.push_back('{"srl",   1'b0, 7'h00, 3'd5, 12'h000, 32'h8000_0000, 32'd4,         32'h0800_0000});
      vecs.push_back('{"sra",   1'b0, 7'h20, 3'd5, 12'h000, 32'h8000_0000, 32'd4,         32'hF800_0000});
      vecs.push_back('{"xor",   1'b0, 7'h00, 3'd4, 12'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
      vecs.push_back('{"or",    1'b0, 7'h00, 3'd6, 12'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0});
      vecs.push_back('{"and",   1'b0, 7'h00, 3'd7, 12'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
      vecs.push_back('{"addi-", 1'b1, 7'h00, 3'd0, 12'hFFD, 32'd5,         32'd0,         32'd2});
      vecs.push_back('{"addi30",1'b1, 7'h00, 3'd0, 12'h400, 32'd10,        32'd0,         32'd1034});
      vecs.push_back('{"srai",  1'b1, 7'h00, 3'd5, 12'h401, 32'hFFFF_FFFD, 32'd0,         32'hFFFF_FFFE});
      vecs.push_back('{"srli",  1'b1, 7'h00, 3'd5, 12'h01F, 32'h8000_0000, 32'd0,         32'd1});
      vecs.push_back('{"sltiu", 1'b1, 7'h00, 3'd3, 12'hFFF, 32'd5,         32'd0,         32'd1});
      vecs.push_back('{"slti",  1'b1, 7'h00, 3'd2, 12'hFFF, 32'd5,         32'd0,         32'd0});
      vecs.push_back('{"andi",  1'b1, 7'h00, 3'd7, 12'h800, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_F800});
      vecs.push_back('{"xori",  1'b1, 7'h00, 3'd4, 12'hFFF, 32'h0000_1234, 32'd0,         32'hFFFF_EDCB});
      vecs.push_back('{"slli",  1'b1, 7'h00, 3'd1, 12'h002, 32'd3,         32'd0,         32'd12});

      // ---------------- reset state (checked while reset is high) ----------------
      clear_program();
      init_regs[1] = 32'd5;
      init_regs[0] = 32'hDEAD_BEEF;
      #1 reset = 1'b1;
      #1;
      check("reset pc",      pc_chk,            32'h0);
      check("reset state",   32'(state_chk),    32'd0);
      check("reset ir",      ir_chk,            32'h0);
      check("reset retired", retired_chk,       32'h0);
      check("reset halted",  32'(halted),       32'd0);
      check("reset x0",      reg_chk[0],        32'h0);
      check("reset x1",      reg_chk[1],        32'd5);
      check("reset dmem0",   dmem_chk[0],       32'h0);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- table-driven single-instruction ALU vectors ----------------
      foreach (vecs[k]) begin
         clear_program();
         init_regs[1] = vecs[k].a;
         init_regs[2] = vecs[k].b;
         init_imem[0] = vecs[k].is_imm ? enc_i(vecs[k].imm, 5'd1, vecs[k].f3, 5'd3, OP_I)
                                       : enc_r(vecs[k].f7, 5'd2, 5'd1, vecs[k].f3, 5'd3);
         apply_reset();
         sb.push_back('{vecs[k].name, vecs[k].expv});
         run(4);
         e = sb.pop_front();
         check(e.name, reg_chk[3], e.value);
         check({e.name, " retired"}, retired_chk, 32'd1);
      end
      check("scoreboard drained", sb.size(), 32'd0);

      // ---------------- ALU sequence, 16 cycles ----------------
      clear_program();
      init_regs[1] = 32'd5;
      init_regs[2] = 32'hFFFF_FFFD;
      init_imem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      init_imem[1] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
      init_imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd5);
      init_imem[3] = enc_i(12'h401, 5'd2, 3'd5, 5'd6, OP_I);
      apply_reset();
      run(15);
      check("seq retired@15", retired_chk, 32'd3);
      check("seq x6@15",      reg_chk[6],  32'h0);
      run(1);
      check("seq x3",         reg_chk[3],  32'd2);
      check("seq x4",         reg_chk[4],  32'd8);
      check("seq x5",         reg_chk[5],  32'd1);
      check("seq x6",         reg_chk[6],  32'hFFFF_FFFE);
      check("seq retired",    retired_chk, 32'd4);
      check("seq pc",         pc_chk,      32'd16);

      // ---------------- SW then LW ----------------
      clear_program();
      init_regs[1] = 32'h40;
      init_imem[0] = enc_s(12'd8, 5'd1, 5'd1);
      init_imem[1] = enc_i(12'd8, 5'd1, 3'b010, 5'd2, OP_LOAD);
      apply_reset();
      run(3);
      check("sw state MEMORY",  32'(state_chk), 32'd3);
      check("sw dmem18 early",  dmem_chk[18],   32'h0);
      run(1);
      check("sw dmem18",        dmem_chk[18],   32'h40);
      check("sw pc",            pc_chk,         32'd4);
      run(4);
      check("lw x2 early",      reg_chk[2],     32'h0);
      run(1);
      check("lw x2",            reg_chk[2],     32'h40);
      check("lw retired",       retired_chk,    32'd2);

      // ---------------- SW address wrap: 0x80 + 0x48 ----------------
      clear_program();
      init_regs[1] = 32'h80;
      init_imem[0] = enc_s(12'h048, 5'd1, 5'd1);
      apply_reset();
      run(4);
      check("wrap dmem18",   dmem_chk[18], 32'h80);
      check("wrap dmem2",    dmem_chk[2],  32'h0);
      check("wrap retired",  retired_chk,  32'd1);

      // ---------------- x0 write and JAL ----------------
      clear_program();
      init_imem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_I);
      init_imem[1] = enc_j(21'd8, 5'd5);
      init_imem[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd6, OP_I);
      init_imem[3] = enc_i(12'd9, 5'd0, 3'd0, 5'd7, OP_I);
      apply_reset();
      run(4);
      check("x0 stays 0",      reg_chk[0],     32'h0);
      run(3);
      check("jal in WB",       32'(state_chk), 32'd4);
      check("jal pc held",     pc_chk,         32'd4);
      run(1);
      check("jal x5",          reg_chk[5],     32'd8);
      check("jal pc",          pc_chk,         32'd12);
      run(4);
      check("jal target x7",   reg_chk[7],     32'd9);
      check("jal skipped x6",  reg_chk[6],     32'h0);
      check("jal retired",     retired_chk,    32'd3);

      // ---------------- JAL to misaligned pc ----------------
      clear_program();
      init_imem[0] = enc_j(21'd2, 5'd1);
      apply_reset();
      run(4);
      check("misalign pc",     pc_chk,         32'd2);
      check("misalign x1",     reg_chk[1],     32'd4);
      run(1);
      check("misalign HALT",   32'(state_chk), 32'd5);

      // ---------------- illegal opcode ----------------
      clear_program();
      for (int i = 1; i < 32; i++) init_regs[i] = 32'h11 * i;
      init_imem[0] = 32'h0;
      apply_reset();
      run(1);
      check("illegal DECODE",  32'(state_chk), 32'd1);
      run(1);
      check("illegal HALT",    32'(state_chk), 32'd5);
      check("illegal halted",  32'(halted),    32'd1);
      run(10);
      mism = 0;
      for (int i = 1; i < 32; i++) if (reg_chk[i] !== 32'h11 * i) mism++;
      check("illegal regs unchanged", mism,    32'd0);
      check("illegal pc",      pc_chk,         32'h0);
      check("illegal retired", retired_chk,    32'h0);

      // ---------------- branch to 4*IMEM_DEPTH ----------------
      clear_program();
      init_imem[0] = enc_b(13'd128, 5'd0, 5'd0, 3'b000);
      apply_reset();
      run(3);
      check("oob pc",          pc_chk,         32'd128);
      check("oob FETCH",       32'(state_chk), 32'd0);
      check("oob retired",     retired_chk,    32'd1);
      run(1);
      check("oob HALT",        32'(state_chk), 32'd5);
      run(3);
      check("oob pc frozen",   pc_chk,         32'd128);

      // ---------------- countdown loop then ECALL ----------------
      clear_program();
      init_regs[1] = 32'd3;
      init_imem[0] = enc_i(12'hFFF, 5'd1, 3'd0, 5'd1, OP_I);
      init_imem[1] = enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001);
      apply_reset();
      cyc = 0;
      while (!halted && cyc < 40) begin
         run(1);
         cyc++;
      end
      check("loop cycles to HALT", cyc,        32'd23);
      check("loop x1",         reg_chk[1],     32'd0);
      check("loop retired",    retired_chk,    32'd6);
      check("loop halted",     32'(halted),    32'd1);
      check("loop pc",         pc_chk,         32'd8);
      run(10);
      check("loop retired frozen", retired_chk, 32'd6);
      check("loop pc frozen",  pc_chk,         32'd8);

      // ---------------- reset during MEMORY of an SW ----------------
      clear_program();
      init_regs[1] = 32'h40;
      init_imem[0] = enc_s(12'd8, 5'd1, 5'd1);
      apply_reset();
      run(3);
      check("rst-mid in MEMORY", 32'(state_chk), 32'd3);
      reset = 1'b1;
      #1;
      check("rst-mid dmem18",  dmem_chk[18],   32'h0);
      check("rst-mid pc",      pc_chk,         32'h0);
      check("rst-mid retired", retired_chk,    32'h0);
      check("rst-mid state",   32'(state_chk), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(4);
      check("rerun dmem18",    dmem_chk[18],   32'h40);
      check("rerun pc",        pc_chk,         32'd4);
      check("rerun retired",   retired_chk,    32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
